// File: rtl/real_mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter and its floating-point multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package real_mul_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int OP_W  = 64;  // operand / result word width
  localparam int CNT_W = 16;  // completed-response counter width
  localparam int LAT_W = 4;   // settle counter width, covers MUL_LAT up to 15

endpackage

// File: rtl/real_mul_arbiter_real_mul.sv
// IEEE-754 multiplier: one double lane, or two packed single lanes (low lane in bits [31:0]).
// Latency: STAGES cycles (0 = combinational, 1 = registered output).
// Backpressure: none; operands must be held stable by the caller until the result is taken.
module real_mul
  import real_mul_arbiter_pkg::*;
#(
  parameter int IS_DOUBLE = 0,
  parameter int STAGES    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op1,
  input  logic [OP_W-1:0] op2,
  output logic [OP_W-1:0] result
);

  localparam int EW    = (IS_DOUBLE != 0) ? 11 : 8;
  localparam int MW    = (IS_DOUBLE != 0) ? 52 : 23;
  localparam int FW    = 1 + EW + MW;
  localparam int LANES = OP_W / FW;
  localparam int BIAS  = (1 << (EW - 1)) - 1;
  localparam int EMAX  = (1 << EW) - 1;

  // Round-to-nearest-even multiply; subnormal inputs and results flush to zero.
  function automatic logic [FW-1:0] fmul(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic          sgn;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic [2*MW+1:0] prod, norm;
    logic [MW:0]   mr;
    logic          rnd;
    int            e;
    sgn  = a[FW-1] ^ b[FW-1];
    ea   = a[FW-2:MW];
    eb   = b[FW-2:MW];
    ma   = a[MW-1:0];
    mb   = b[MW-1:0];
    prod = {{(MW+1){1'b0}}, 1'b1, ma} * {{(MW+1){1'b0}}, 1'b1, mb};
    // Product of two [1,2) significands lies in [1,4): shift so the leading one is at the top.
    norm = prod[2*MW+1] ? prod : (prod << 1);
    e    = int'(ea) + int'(eb) - BIAS + (prod[2*MW+1] ? 1 : 0);
    rnd  = norm[MW] & ((|norm[MW-1:0]) | norm[MW+1]);
    mr   = {1'b0, norm[2*MW:MW+1]} + {{MW{1'b0}}, rnd};
    if (mr[MW]) e = e + 1;
    if (((&ea) && ma != '0) || ((&eb) && mb != '0) ||
        ((&ea) && eb == '0) || ((&eb) && ea == '0))
      fmul = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    else if ((&ea) || (&eb))
      fmul = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else if (ea == '0 || eb == '0)
      fmul = {sgn, {(FW-1){1'b0}}};
    else if (e >= EMAX)
      fmul = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else if (e <= 0)
      fmul = {sgn, {(FW-1){1'b0}}};
    else
      fmul = {sgn, e[EW-1:0], mr[MW-1:0]};
  endfunction

  logic [OP_W-1:0] comb_res;

  // Evaluate every lane of the packed operands
  always_comb begin
    comb_res = '0;
    for (int l = 0; l < LANES; l++)
      comb_res[l*FW +: FW] = fmul(op1[l*FW +: FW], op2[l*FW +: FW]);
  end

  if (STAGES > 0) begin : g_reg
    // Register the product to break the long multiply path
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) result <= '0;
      else      result <= comb_res;
    end
  end else begin : g_comb
    assign result = comb_res;
  end

endmodule

// File: rtl/real_mul_arbiter.sv
// Round-robin arbiter sharing one floating-point multiplier among N_REQ requesters.
// Latency: rsp_valid rises MUL_LAT cycles after the accept edge; one operation in flight.
// Backpressure: result held in RESP until rsp_ready; req_ready is low outside IDLE.
module real_mul_arbiter
  import real_mul_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int IS_DOUBLE = 0,
  parameter  int MUL_LAT   = 2,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_op1,
  input  logic [OP_W*N_REQ-1:0] req_op2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [OP_W-1:0]       rsp_result,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] idx;
  logic            gnt_any;
  logic [LAT_W-1:0] lat_cnt;
  logic [OP_W-1:0] op1_q;
  logic [OP_W-1:0] op2_q;
  logic [OP_W-1:0] mul_res;

  // Pick the first active requester at or after rr_ptr (lowest search offset wins)
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // One-hot accept, only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rst && state == ST_IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

  // Arbitration, settle countdown and response hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      lat_cnt    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            op1_q   <= req_op1[gnt_idx*OP_W +: OP_W];
            op2_q   <= req_op2[gnt_idx*OP_W +: OP_W];
            rsp_id  <= gnt_idx;
            rr_ptr  <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            lat_cnt <= LAT_W'(MUL_LAT - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt == '0) begin
            rsp_result <= mul_res;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A registered multiplier stage fits whenever at least two settle cycles are allowed
  real_mul #(
    .IS_DOUBLE(IS_DOUBLE),
    .STAGES   ((MUL_LAT >= 2) ? 1 : 0)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .op1   (op1_q),
    .op2   (op2_q),
    .result(mul_res)
  );

endmodule

// File: tb/tb_real_mul_arbiter.sv
// Directed bench for real_mul_arbiter with an expected-response queue.
// Drives inputs 1 time unit after the rising edge and samples 1 unit later.
// Covers reset, single op, backpressure, operand change, reset mid-op, contention, counter wrap.
module tb_real_mul_arbiter;

  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  logic [64*N_REQ-1:0] req_op1;
  logic [64*N_REQ-1:0] req_op2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_result;
  logic              busy;
  logic [15:0]       ops_done;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] res;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_done = 16'h0;

  always #5 clk = ~clk;

  real_mul_arbiter #(
    .N_REQ    (N_REQ),
    .IS_DOUBLE(0),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op1[i*64 +: 64] = {32'h0, a};
    req_op2[i*64 +: 64] = {32'h0, b};
  endtask

  task automatic push_exp(input int id, input logic [31:0] prod);
    exp_t e;
    e.id  = 2'(id);
    e.res = {32'h0, prod};
    exp_q.push_back(e);
  endtask

  // Request from IDLE, expect a grant to gnt, then check latency, result, hold and handshake.
  task automatic do_txn(input logic [3:0] vld, input int gnt, input logic [3:0] vld_after,
                        input int hold, input bit poke_op);
    exp_t e;
    int   lat;
    req_valid = vld;
    #1;
    check("grant", 64'(req_ready), 64'(1 << gnt));
    @(posedge clk); #1;
    req_valid = vld_after;
    if (poke_op) req_op1[gnt*64 +: 64] = 64'h3F800000;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("ready_in_busy", 64'(req_ready), 64'd0);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(MUL_LAT));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    check("rsp_id", 64'(rsp_id), 64'(e.id));
    check("rsp_result", rsp_result, e.res);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'(e.id));
      check("hold_result", rsp_result, e.res);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_done++;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("ops_done", 64'(ops_done), 64'(exp_done));
    check("idle_gap", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst       = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_op1   = '0;
    req_op2   = '0;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 32'h40000000, 32'h40400000);
    repeat (2) @(posedge clk);
    #1;
    // Reset values, with all requesters active during reset
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_ops_done", 64'(ops_done), 64'd0);
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_no_req", 64'(busy), 64'd0);

    // Single request: 2.0 * 3.0 from requester 1
    set_lane(1, 32'h40000000, 32'h40400000);
    push_exp(1, 32'h40C00000);
    do_txn(4'b0010, 1, 4'b0000, 0, 1'b0);

    // Backpressure for 10 cycles plus operand change after accept: 1.5 * 1.5
    set_lane(2, 32'h3FC00000, 32'h3FC00000);
    push_exp(2, 32'h40100000);
    do_txn(4'b0100, 2, 4'b0000, 10, 1'b1);

    // Reset one cycle after accepting requester 1
    set_lane(1, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    #1;
    check("rst_test_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_ops_done", 64'(ops_done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_done = 16'h0;
    seen = 1'b0;
    repeat (3 * MUL_LAT + 6) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);
    check("midrst_ops_after", 64'(ops_done), 64'd0);

    // Contention: all four held, grant order restarts at 0 after reset
    set_lane(0, 32'h40400000, 32'h40800000);
    set_lane(1, 32'h40000000, 32'h40400000);
    set_lane(2, 32'hC0000000, 32'h3F000000);
    set_lane(3, 32'h00000000, 32'h40A00000);
    push_exp(0, 32'h41400000);
    push_exp(1, 32'h40C00000);
    push_exp(2, 32'hBF800000);
    push_exp(3, 32'h00000000);
    push_exp(0, 32'h41400000);
    do_txn(4'b1111, 0, 4'b1111, 0, 1'b0);
    do_txn(4'b1111, 1, 4'b1111, 0, 1'b0);
    do_txn(4'b1111, 2, 4'b1111, 0, 1'b0);
    do_txn(4'b1111, 3, 4'b1111, 0, 1'b0);
    do_txn(4'b1111, 0, 4'b0000, 0, 1'b0);

    // Counter wrap: preload near the top, then two completions
    @(negedge clk);
    force dut.ops_done = 16'hFFFE;
    #1;
    release dut.ops_done;
    exp_done = 16'hFFFE;
    @(posedge clk); #1;
    push_exp(1, 32'h40C00000);
    do_txn(4'b0010, 1, 4'b0000, 0, 1'b0);
    push_exp(1, 32'h40C00000);
    do_txn(4'b0010, 1, 4'b0000, 0, 1'b0);
    check("wrap_zero", 64'(ops_done), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
